// File: rtl/fp_acc_to_fp16.sv
// rtl/fp_acc_to_fp16.sv - accumulator (exponent + fixed-point) to FP16 converter
//
// Takes the MAC result as a biased exponent plus a two's-complement fixed-point
// word, normalizes it one left shift per cycle, then rounds to nearest-even and
// packs an FP16 word. Out-of-range results saturate to max finite or flush to
// zero. NaR maps to 16'h7E00.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   start           request, sampled only while ready is high
//   exp_in          FP16 biased exponent of fixed_point_in
//   fixed_point_in  signed accumulator value, LSB weight 2^(exp_in-15-FRAC_BITS)
//   NaR_in          input is NaR
//   ready           idle, a new start may be accepted (also high in the done cycle)
//   act_out         packed FP16 result, held until the next done
//   done            one-cycle pulse, act_out and flags valid
//   NaR_out         result is NaR
//   overflow        result saturated to max finite
//   underflow       result flushed to zero

module fp_acc_to_fp16 #(
   parameter int ACC_WIDTH = 32,
   parameter int FRAC_BITS = 10,
   parameter int ACT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4:0]           exp_in,
   input  logic [ACC_WIDTH-1:0] fixed_point_in,
   input  logic                 NaR_in,
   output logic                 ready,
   output logic [ACT_WIDTH-1:0] act_out,
   output logic                 done,
   output logic                 NaR_out,
   output logic                 overflow,
   output logic                 underflow
);

   localparam logic [7:0] FRAC_W = 8'(FRAC_BITS);

   typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;

   state_t                 state_q, state_d;
   logic [31:0]            mag_q, mag_d;
   logic [4:0]             lz_q, lz_d;
   logic [4:0]             exp_q, exp_d;
   logic                   sign_q, sign_d;
   logic                   nar_q, nar_d;
   logic [ACT_WIDTH-1:0]   act_q, act_d;
   logic                   done_q, done_d;
   logic                   nar_out_q, nar_out_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic [31:0]            mag_in;
   logic                   round_up;
   logic [10:0]            m_sum;
   logic [7:0]             e_raw;
   logic [7:0]             e_rnd;

   // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
   assign mag_in = fixed_point_in[31] ? (~fixed_point_in + 32'd1) : fixed_point_in;

   // Once normalized, mag[31] is the hidden one; mag[30:21] is the mantissa.
   assign round_up = mag_q[20] & ((|mag_q[19:0]) | mag_q[21]);
   assign m_sum    = {1'b0, mag_q[30:21]} + {10'd0, round_up};

   // 8-bit modular arithmetic read as signed covers the full exponent range.
   assign e_raw = {3'b000, exp_q} + 8'd31 - {3'b000, lz_q} - FRAC_W;
   // A mantissa carry leaves m_sum[9:0] at zero, so only the exponent bumps.
   assign e_rnd = e_raw + {7'd0, m_sum[10]};

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      lz_d      = lz_q;
      exp_d     = exp_q;
      sign_d    = sign_q;
      nar_d     = nar_q;
      act_d     = act_q;
      done_d    = 1'b0;
      nar_out_d = nar_out_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               exp_d  = exp_in;
               nar_d  = NaR_in;
               sign_d = fixed_point_in[31];
               mag_d  = mag_in;
               lz_d   = 5'd0;
               // Zero and NaR skip normalization entirely.
               if (NaR_in || (mag_in == 32'd0)) begin
                  state_d = ROUND;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (!mag_q[31]) begin
               mag_d = mag_q << 1;
               lz_d  = lz_q + 5'd1;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            done_d    = 1'b1;
            state_d   = IDLE;
            nar_out_d = 1'b0;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            if (nar_q) begin
               act_d     = 16'h7E00;
               nar_out_d = 1'b1;
            end else if (mag_q == 32'd0) begin
               act_d = 16'h0000;
            end else if ($signed(e_rnd) >= 8'sd31) begin
               act_d = {sign_q, 15'h7BFF};
               ovf_d = 1'b1;
            end else if ($signed(e_rnd) <= 8'sd0) begin
               act_d = 16'h0000;
               unf_d = 1'b1;
            end else begin
               act_d = {sign_q, e_rnd[4:0], m_sum[9:0]};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         mag_q     <= '0;
         lz_q      <= '0;
         exp_q     <= '0;
         sign_q    <= 1'b0;
         nar_q     <= 1'b0;
         act_q     <= '0;
         done_q    <= 1'b0;
         nar_out_q <= 1'b0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         lz_q      <= lz_d;
         exp_q     <= exp_d;
         sign_q    <= sign_d;
         nar_q     <= nar_d;
         act_q     <= act_d;
         done_q    <= done_d;
         nar_out_q <= nar_out_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign act_out   = act_q;
   assign done      = done_q;
   assign NaR_out   = nar_out_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_fp_acc_to_fp16.sv
// tb/tb_fp_acc_to_fp16.sv - self-checking bench for fp_acc_to_fp16

module tb_fp_acc_to_fp16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  exp_in;
   logic [31:0] fixed_point_in;
   logic        NaR_in;
   logic        ready;
   logic [15:0] act_out;
   logic        done;
   logic        NaR_out;
   logic        overflow;
   logic        underflow;

   int checks;
   int failures;

   fp_acc_to_fp16 #(.ACC_WIDTH(32), .FRAC_BITS(10), .ACT_WIDTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .exp_in         (exp_in),
      .fixed_point_in (fixed_point_in),
      .NaR_in         (NaR_in),
      .ready          (ready),
      .act_out        (act_out),
      .done           (done),
      .NaR_out        (NaR_out),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value = mag * 2^(ex-15-10); find the leading one, round the
   // bits below the 10-bit mantissa against half an ulp, then classify.
   function automatic void model(input logic [31:0] fp, input logic [4:0] ex, input logic nar,
                                 output logic [15:0] act, output logic en, output logic eo,
                                 output logic eu, output int lat);
      longint unsigned m;
      longint unsigned rem;
      longint unsigned half;
      int p;
      int e;
      int sh;
      int mant;
      logic sgn;
      logic [4:0] e5;
      logic [9:0] m10;
      en = 1'b0; eo = 1'b0; eu = 1'b0; act = 16'h0000; lat = 1;
      if (nar) begin
         act = 16'h7E00;
         en  = 1'b1;
         return;
      end
      sgn = fp[31];
      m = sgn ? (64'h1_0000_0000 - {32'd0, fp}) : {32'd0, fp};
      if (m == 0) return;
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      lat = (31 - p) + 2;
      e = int'(ex) + p - 10;
      if (p > 10) begin
         sh   = p - 10;
         mant = int'((m >> sh) & 64'h3FF);
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && mant % 2 == 1)) mant = mant + 1;
      end else begin
         mant = int'((m << (10 - p)) & 64'h3FF);
      end
      if (mant == 1024) begin
         mant = 0;
         e = e + 1;
      end
      if (e >= 31) begin
         act = {sgn, 15'h7BFF};
         eo  = 1'b1;
      end else if (e <= 0) begin
         eu = 1'b1;
      end else begin
         e5  = 5'(e);
         m10 = 10'(mant);
         act = {sgn, e5, m10};
      end
   endfunction

   // Drives one request and waits (bounded) for done; leaves time in the done cycle.
   task automatic do_op(input logic [31:0] fp, input logic [4:0] ex, input logic nar,
                        output int lat, output logic rdy_at_done);
      @(negedge clk);
      fixed_point_in = fp;
      exp_in         = ex;
      NaR_in         = nar;
      start          = 1'b1;
      @(posedge clk);
      #1;
      start          = 1'b0;
      fixed_point_in = $urandom;
      exp_in         = 5'($urandom);
      NaR_in         = 1'($urandom);
      lat = 0;
      while (lat < 40 && done !== 1'b1) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdy_at_done = ready;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      exp_in = 5'd0;
      fixed_point_in = 32'd0;
      NaR_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({ready, act_out, done, NaR_out, overflow, underflow} !== {1'b1, 16'h0000, 4'b0000}) begin
         failures++;
         $display("FAIL reset_state: got ready=%0b act=%h done=%0b nar=%0b ovf=%0b unf=%0b want ready=1 act=0000 others 0",
                  ready, act_out, done, NaR_out, overflow, underflow);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [31:0] fp;
      logic [4:0]  ex;
      logic        nar;
      logic [15:0] act;
      logic [2:0]  flags;
      int          lat;
   } vec_t;

   task automatic test_directed();
      vec_t v[$];
      int lat;
      logic rdy;
      v.push_back('{32'h0000_0400, 5'd15, 1'b0, 16'h3C00, 3'b000, 23});
      v.push_back('{32'hFFFF_FC00, 5'd15, 1'b0, 16'hBC00, 3'b000, 23});
      v.push_back('{32'h0000_0FFF, 5'd15, 1'b0, 16'h4400, 3'b000, 22});
      v.push_back('{32'h0000_0C01, 5'd15, 1'b0, 16'h4200, 3'b000, 22});
      v.push_back('{32'h0000_0C03, 5'd15, 1'b0, 16'h4202, 3'b000, 22});
      v.push_back('{32'h8000_0000, 5'd15, 1'b0, 16'hFBFF, 3'b010, 2});
      v.push_back('{32'h7FFF_FFFF, 5'd15, 1'b0, 16'h7BFF, 3'b010, 3});
      v.push_back('{32'h0000_0001, 5'd5,  1'b0, 16'h0000, 3'b001, 33});
      v.push_back('{32'h1234_5678, 5'd9,  1'b1, 16'h7E00, 3'b100, 1});
      v.push_back('{32'h0000_0000, 5'd15, 1'b0, 16'h0000, 3'b000, 1});
      foreach (v[i]) begin
         do_op(v[i].fp, v[i].ex, v[i].nar, lat, rdy);
         checks++;
         if (act_out !== v[i].act || {NaR_out, overflow, underflow} !== v[i].flags) begin
            failures++;
            $display("FAIL directed_%0d result: got act=%h flags=%b want act=%h flags=%b",
                     i, act_out, {NaR_out, overflow, underflow}, v[i].act, v[i].flags);
         end
         checks++;
         if (lat !== v[i].lat) begin
            failures++;
            $display("FAIL directed_%0d latency: got %0d want %0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      int extra_done;
      @(negedge clk);
      fixed_point_in = 32'h0000_0400;
      exp_in = 5'd15;
      NaR_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: got %0b want 0", ready);
         end
         start = 1'b1;
         fixed_point_in = $urandom;
         exp_in = 5'($urandom);
         NaR_in = 1'($urandom);
         @(posedge clk);
         #1;
         start = 1'b0;
         lat++;
      end
      while (lat < 40 && done !== 1'b1) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat !== 23 || act_out !== 16'h3C00 || {NaR_out, overflow, underflow} !== 3'b000) begin
         failures++;
         $display("FAIL ignored_start: got lat=%0d act=%h flags=%b want lat=23 act=3c00 flags=000",
                  lat, act_out, {NaR_out, overflow, underflow});
      end
      extra_done = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (done === 1'b1 || ready !== 1'b1) extra_done++;
      end
      checks++;
      if (extra_done !== 0) begin
         failures++;
         $display("FAIL no_queued_start: got %0d busy/done cycles want 0", extra_done);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] fp;
      logic [4:0]  ex;
      logic [15:0] e_act;
      logic        en, eo, eu, rdy;
      int          e_lat, lat;
      for (int i = 0; i < 4; i++) begin
         fp = 32'h0000_1000 << i;
         ex = 5'(10 + i);
         model(fp, ex, 1'b0, e_act, en, eo, eu, e_lat);
         do_op(fp, ex, 1'b0, lat, rdy);
         checks++;
         if (rdy !== 1'b1 || lat !== e_lat || act_out !== e_act) begin
            failures++;
            $display("FAIL back_to_back_%0d: got ready=%0b lat=%0d act=%h want ready=1 lat=%0d act=%h",
                     i, rdy, lat, act_out, e_lat, e_act);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] fp;
      logic [4:0]  ex;
      logic        nar;
      logic [15:0] e_act;
      logic        en, eo, eu, rdy;
      int          e_lat, lat;
      for (int i = 0; i < 200; i++) begin
         fp  = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) fp = -fp;
         if ($urandom_range(0, 19) == 0) fp = 32'd0;
         ex  = 5'($urandom);
         nar = ($urandom_range(0, 15) == 0);
         model(fp, ex, nar, e_act, en, eo, eu, e_lat);
         do_op(fp, ex, nar, lat, rdy);
         checks++;
         if (act_out !== e_act) begin
            failures++;
            $display("FAIL random_%0d act: in fp=%h exp=%0d nar=%0b got %h want %h",
                     i, fp, ex, nar, act_out, e_act);
         end
         checks++;
         if ({NaR_out, overflow, underflow} !== {en, eo, eu}) begin
            failures++;
            $display("FAIL random_%0d flags: in fp=%h exp=%0d got %b want %b",
                     i, fp, ex, {NaR_out, overflow, underflow}, {en, eo, eu});
         end
         checks++;
         if (lat !== e_lat) begin
            failures++;
            $display("FAIL random_%0d latency: in fp=%h got %0d want %0d", i, fp, lat, e_lat);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      int seen_done;
      @(negedge clk);
      fixed_point_in = 32'h0000_0001;
      exp_in = 5'd20;
      NaR_in = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({ready, act_out, done, NaR_out, overflow, underflow} !== {1'b1, 16'h0000, 4'b0000}) begin
         failures++;
         $display("FAIL mid_reset_state: got ready=%0b act=%h done=%0b nar=%0b ovf=%0b unf=%0b want ready=1 act=0000 others 0",
                  ready, act_out, done, NaR_out, overflow, underflow);
      end
      @(negedge clk);
      rst = 1'b1;
      seen_done = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) seen_done++;
      end
      checks++;
      if (seen_done !== 0 || ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_abort: got done_count=%0d ready=%0b want done_count=0 ready=1",
                  seen_done, ready);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_start_ignored();
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
